layer_4_maxpool_2x2: RTL and testbench
======================================

Name: layer_4_maxpool_2x2

Overview:
- Streaming 2x2, stride-2 max-pool stage placed directly downstream of the layer-4 conv/feature-map output (after bias/activation).
- Consumes an FP32 raster stream of IMG_SIZE x IMG_SIZE pixels, one pixel per valid_in beat.
- Emits a (IMG_SIZE/2) x (IMG_SIZE/2) raster, e.g. 104 -> 52, for the layer-5 input.
- Up to CHANNELS lanes are processed in lockstep, each with its own independent datapath.

Parameters:
DATA_WIDTH, 32, bits per lane (IEEE-754 single).
CHANNELS, 1, number of parallel lanes packed in data_in/data_out; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
IMG_SIZE, 104, input frame width and height; must be even and >= 2.

Ports:
Clk  in  1  clock; all logic on rising edge.
Rst  in  1  synchronous, active-high reset.
data_in  in  DATA_WIDTH*CHANNELS  input pixel, raster order (row-major, column fastest).
valid_in  in  1  data_in is accepted this cycle; no backpressure.
data_out  out  DATA_WIDTH*CHANNELS  pooled pixel.
valid_out  out  1  one-cycle pulse; data_out valid.
last_out  out  1  asserted with valid_out on the final pooled pixel of a frame.

Behaviour:
- One clock (Clk). Reset is synchronous, active-high (Rst).
- Reset values: data_out=0, valid_out=0, last_out=0, col=0, row=0, pair register=0. Line buffer is not cleared; every entry is written on an even row before it is read.
- Counters: col advances 0..IMG_SIZE-1 only on valid_in. At col wrap, row advances 0..IMG_SIZE-1. At row wrap, both return to 0 and the next frame begins on the next beat, with no idle gap required.
- Compare function, applied per lane:
  - key(x) = x[31] ? ~x : (x | 32'h80000000); the larger unsigned key wins.
  - Ties keep the first operand.
  - Result: +0 > -0, +inf > any finite, NaN ordered by bit pattern. No NaN special-casing.
- Even col beat: pair register <= data_in.
- Odd col beat: hm = max(pair, data_in).
  - Even row: linebuf[col>>1] <= hm.
  - Odd row: result = max(linebuf[col>>1], hm).
- Output timing: data_out <= result, valid_out=1 on the cycle after the odd-row, odd-col beat (latency 1 cycle from the 4th pixel of a block). Otherwise valid_out=0 and data_out holds its last value.
- last_out=1 only when the result comes from row=IMG_SIZE-1, col=IMG_SIZE-1.
- Line buffer: IMG_SIZE/2 entries x DATA_WIDTH*CHANNELS, one write or one read per beat, never both to the same address in one cycle.
- Throughput: accepts valid_in every cycle. Outputs <= 1 per 2 cycles, only during odd rows. Exactly (IMG_SIZE/2)^2 outputs per frame (2704 at default).
- valid_in gaps of any length: all state holds and results are unchanged.
- Rst mid-frame: partial frame discarded, no output produced from it. A pending valid_out in the reset cycle is dropped (outputs forced to reset values). The first beat after Rst is pixel (0,0).
- Lanes are fully independent: no cross-lane comparison.

Test Plan:
1. IMG_SIZE=4, CHANNELS=1, floats 1.0..16.0 in raster order, continuous valid_in -> four valid_out pulses: 0x40C00000 (6.0), 0x41000000 (8.0), 0x41600000 (14.0), 0x41800000 (16.0). Each pulse is 1 cycle after pixels 6, 8, 14, 16. last_out only on the 16.0 output.
2. IMG_SIZE=2, block {-1.0,-2.0,-0.5,-3.0} -> 0xBF000000. Block {0x80000000,0x80000000,0x00000000,0x80000000} -> 0x00000000. Block {0xFF800000 x3, 0xC2C80000} -> 0xC2C80000 (-100.0).
3. Rerun test 1 with random 0-5 cycle valid_in gaps -> identical data_out sequence. Each valid_out exactly 1 cycle after the accepted 4th block pixel; no valid_out during gaps.
4. IMG_SIZE=4: 5 pixels, assert Rst 1 cycle mid-stream, then full frame 1.0..16.0 -> exactly 4 outputs as in test 1, none from the aborted partial frame.
5. Default IMG_SIZE=104, two back-to-back random frames -> 2704 outputs per frame matching the golden model. last_out pulses exactly twice, on outputs 2704 and 5408.
6. CHANNELS=2, IMG_SIZE=4: lane0 = test-1 data, lane1 = its negation -> lane0 gives 6,8,14,16; lane1 gives -1.0,-3.0,-9.0,-11.0 (0xBF800000, 0xC0400000, 0xC1100000, 0xC1300000), on the same cycles.

Source files
------------

// File: rtl/layer_4_maxpool_2x2.sv
// Streaming 2x2, stride-2 max-pool over an FP32 raster with CHANNELS independent lanes.
// Horizontal pairs fold through a pair register; vertical pairs fold through a half-width line buffer.
module layer_4_maxpool_2x2 #(
   parameter int DATA_WIDTH = 32,
   parameter int CHANNELS   = 1,
   parameter int IMG_SIZE   = 104
) (
   input  logic                           Clk,
   input  logic                           Rst,
   input  logic [DATA_WIDTH*CHANNELS-1:0] data_in,
   input  logic                           valid_in,
   output logic [DATA_WIDTH*CHANNELS-1:0] data_out,
   output logic                           valid_out,
   output logic                           last_out
);

   localparam int BUS_W = DATA_WIDTH * CHANNELS;
   localparam int HALF  = IMG_SIZE / 2;
   localparam int COL_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int ROW_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

   localparam logic [COL_W-1:0]      LAST_PCOL = COL_W'(HALF - 1);
   localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_SIZE - 1);
   localparam logic [DATA_WIDTH-1:0] SIGN_BIT  = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

   // Maps an IEEE-754 pattern onto an unsigned key whose ordering matches the float ordering.
   function automatic logic [DATA_WIDTH-1:0] order_key(input logic [DATA_WIDTH-1:0] x);
      return x[DATA_WIDTH-1] ? ~x : (x | SIGN_BIT);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
      return (order_key(b) > order_key(a)) ? b : a;
   endfunction

   // Column is split into an odd/even phase and a pair index that addresses the line buffer.
   logic             phase_q, phase_d;
   logic [COL_W-1:0] pcol_q,  pcol_d;
   logic [ROW_W-1:0] row_q,   row_d;
   logic [BUS_W-1:0] pair_q,  pair_d;
   logic [BUS_W-1:0] dout_q,  dout_d;
   logic             valid_q, valid_d;
   logic             last_q,  last_d;

   logic [BUS_W-1:0] linebuf [HALF];
   logic [BUS_W-1:0] lb_rd;
   logic             lb_we;
   logic [BUS_W-1:0] hm;
   logic [BUS_W-1:0] res;

   assign lb_rd = linebuf[pcol_q];

   always_comb begin
      hm  = '0;
      res = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         hm[k*DATA_WIDTH +: DATA_WIDTH]  = fp_max(pair_q[k*DATA_WIDTH +: DATA_WIDTH],
                                                  data_in[k*DATA_WIDTH +: DATA_WIDTH]);
         res[k*DATA_WIDTH +: DATA_WIDTH] = fp_max(lb_rd[k*DATA_WIDTH +: DATA_WIDTH],
                                                  hm[k*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      phase_d = phase_q;
      pcol_d  = pcol_q;
      row_d   = row_q;
      pair_d  = pair_q;
      dout_d  = dout_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
      lb_we   = 1'b0;
      if (valid_in) begin
         if (!phase_q) begin
            pair_d  = data_in;
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            if (pcol_q == LAST_PCOL) begin
               pcol_d = '0;
               row_d  = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
            end else begin
               pcol_d = pcol_q + COL_W'(1);
            end
            if (!row_q[0]) begin
               lb_we = 1'b1;
            end else begin
               dout_d  = res;
               valid_d = 1'b1;
               last_d  = (row_q == LAST_ROW) && (pcol_q == LAST_PCOL);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         phase_q <= 1'b0;
         pcol_q  <= '0;
         row_q   <= '0;
         pair_q  <= '0;
         dout_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         pcol_q  <= pcol_d;
         row_q   <= row_d;
         pair_q  <= pair_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   // NOTE: the line buffer has no reset; each entry is written on an even row before any odd-row read.
   always_ff @(posedge Clk) begin
      if (lb_we) begin
         linebuf[pcol_q] <= hm;
      end
   end

   assign data_out  = dout_q;
   assign valid_out = valid_q;
   assign last_out  = last_q;

endmodule

// File: tb/tb_layer_4_maxpool_2x2.sv
// Bench for layer_4_maxpool_2x2: three instances (4x4 two-lane, 2x2, default 104x104) checked
// every cycle against a frame-array model of 2x2 max pooling with float ordering.
`timescale 1ns/1ps
module tb_layer_4_maxpool_2x2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst4, rst2, rst104;
   logic        vin4, vin2, vin104;
   logic [63:0] din4;
   logic [31:0] din2, din104;
   logic [63:0] dout4;
   logic [31:0] dout2, dout104;
   logic        vout4, vout2, vout104;
   logic        lout4, lout2, lout104;

   layer_4_maxpool_2x2 #(.DATA_WIDTH(32), .CHANNELS(2), .IMG_SIZE(4)) u4 (
      .Clk(clk), .Rst(rst4), .data_in(din4), .valid_in(vin4),
      .data_out(dout4), .valid_out(vout4), .last_out(lout4));

   layer_4_maxpool_2x2 #(.DATA_WIDTH(32), .CHANNELS(1), .IMG_SIZE(2)) u2 (
      .Clk(clk), .Rst(rst2), .data_in(din2), .valid_in(vin2),
      .data_out(dout2), .valid_out(vout2), .last_out(lout2));

   layer_4_maxpool_2x2 u104 (
      .Clk(clk), .Rst(rst104), .data_in(din104), .valid_in(vin104),
      .data_out(dout104), .valid_out(vout104), .last_out(lout104));

   typedef struct {
      logic [63:0] data;
      logic        last;
      int          due;
   } exp_t;

   exp_t        exp_q   [3][$];
   logic [63:0] frame   [3][104*104];
   logic [63:0] held    [3];
   int          pos     [3];
   int          out_cnt [3];
   int          last_cnt[3];
   int          checks = 0;
   int          errors = 0;

   localparam logic [31:0] F [16] = '{
      32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
      32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
      32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
      32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int img(input int id);
      return (id == 0) ? 4 : (id == 1) ? 2 : 104;
   endfunction

   function automatic int lanes(input int id);
      return (id == 0) ? 2 : 1;
   endfunction

   // Float ordering: positive beats negative; among positives larger magnitude wins,
   // among negatives smaller magnitude wins; equal patterns keep the first operand.
   function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
      if (a[31] != b[31]) return a[31] ? b : a;
      if (!a[31])         return (b[30:0] > a[30:0]) ? b : a;
      return (b[30:0] < a[30:0]) ? b : a;
   endfunction

   function automatic logic [31:0] pool(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
      return fmax(fmax(c, d) == fmax(c, d) ? fmax(a, b) : 32'h0, fmax(c, d));
   endfunction

   function automatic logic [63:0] lane_mask(input int id, input logic [63:0] d);
      return (lanes(id) == 2) ? d : {32'h0, d[31:0]};
   endfunction

   function automatic logic get_rst(input int id);
      case (id)
         0:       return rst4;
         1:       return rst2;
         default: return rst104;
      endcase
   endfunction

   task automatic drive(input int id, input logic [63:0] d, input logic v, input logic r);
      case (id)
         0:       begin din4   = d;       vin4   = v; rst4   = r; end
         1:       begin din2   = d[31:0]; vin2   = v; rst2   = r; end
         default: begin din104 = d[31:0]; vin104 = v; rst104 = r; end
      endcase
   endtask

   // One clock of stimulus; the model tracks raster position and queues the expected result
   // for the cycle right after each accepted odd-row, odd-column pixel.
   task automatic beat(input int id, input logic [63:0] d, input logic v, input logic r);
      int   n, p, rr, cc;
      exp_t e;
      n = img(id);
      drive(id, d, v, r);
      @(posedge clk);
      #1;
      drive(id, 64'($urandom), 1'b0, 1'b0);
      if (r) begin
         pos[id] = 0;
      end else if (v) begin
         p = pos[id];
         frame[id][p] = lane_mask(id, d);
         rr = p / n;
         cc = p % n;
         if ((rr % 2 == 1) && (cc % 2 == 1)) begin
            e.data = '0;
            for (int k = 0; k < lanes(id); k++) begin
               e.data[k*32 +: 32] = pool(frame[id][p-n-1][k*32 +: 32], frame[id][p-n][k*32 +: 32],
                                         frame[id][p-1][k*32 +: 32],   frame[id][p][k*32 +: 32]);
            end
            e.last = (p == n*n - 1);
            e.due  = cyc;
            exp_q[id].push_back(e);
         end
         pos[id] = (p == n*n - 1) ? 0 : p + 1;
      end
   endtask

   task automatic idle(input int id, input int n);
      for (int i = 0; i < n; i++) beat(id, 64'($urandom), 1'b0, 1'b0);
   endtask

   task automatic monitor_step(input int id);
      logic        r, v, l;
      logic [63:0] d;
      exp_t        e;
      @(posedge clk);
      r = get_rst(id);
      @(negedge clk);
      case (id)
         0:       begin v = vout4;   l = lout4;   d = dout4;             end
         1:       begin v = vout2;   l = lout2;   d = {32'h0, dout2};    end
         default: begin v = vout104; l = lout104; d = {32'h0, dout104};  end
      endcase
      if (r) held[id] = '0;
      if (v) begin
         out_cnt[id]++;
         if (l) last_cnt[id]++;
         if (exp_q[id].size() == 0) begin
            check($sformatf("u%0d valid_out with nothing pending", id), {63'h0, v}, 64'h0);
         end else begin
            e = exp_q[id].pop_front();
            check($sformatf("u%0d data_out #%0d", id, out_cnt[id]), d, e.data);
            check($sformatf("u%0d last_out #%0d", id, out_cnt[id]), {63'h0, l}, {63'h0, e.last});
            check($sformatf("u%0d output cycle #%0d", id, out_cnt[id]), 64'(cyc), 64'(e.due));
         end
         held[id] = d;
      end else begin
         if (exp_q[id].size() != 0 && exp_q[id][0].due <= cyc) begin
            e = exp_q[id].pop_front();
            check($sformatf("u%0d missing valid_out due %0d", id, e.due), {63'h0, v}, 64'h1);
         end
         check($sformatf("u%0d last_out without valid", id), {63'h0, l}, 64'h0);
         check($sformatf("u%0d data_out hold", id), d, held[id]);
      end
   endtask

   initial forever monitor_step(0);
   initial forever monitor_step(1);
   initial forever monitor_step(2);

   function automatic logic [31:0] rnd_px();
      case ($urandom_range(0, 7))
         0:       return 32'h00000000;
         1:       return 32'h80000000;
         2:       return 32'h7F800000;
         3:       return 32'hFF800000;
         4:       return 32'h7FC00000 | 32'($urandom_range(0, 15));
         5:       return 32'($urandom) & 32'h8000000F;
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic frame4(input int gap_max);
      for (int i = 0; i < 16; i++) begin
         beat(0, {F[i] ^ 32'h80000000, F[i]}, 1'b1, 1'b0);
         if (gap_max > 0) idle(0, $urandom_range(0, gap_max));
      end
   endtask

   logic [31:0] blk [3][4];
   int          base;

   initial begin
      for (int i = 0; i < 3; i++) begin
         held[i] = '0; pos[i] = 0; out_cnt[i] = 0; last_cnt[i] = 0;
         drive(i, '0, 1'b0, 1'b1);
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) drive(i, '0, 1'b0, 1'b0);
      check("reset data_out u4",    dout4, 64'h0);
      check("reset valid_out u4",   {63'h0, vout4}, 64'h0);
      check("reset last_out u4",    {63'h0, lout4}, 64'h0);
      check("reset data_out u2",    {32'h0, dout2}, 64'h0);
      check("reset valid_out u104", {63'h0, vout104}, 64'h0);

      check("model 4x4 blk0", {32'h0, pool(F[0],  F[1],  F[4],  F[5])},  64'h40C00000);
      check("model 4x4 blk1", {32'h0, pool(F[2],  F[3],  F[6],  F[7])},  64'h41000000);
      check("model 4x4 blk2", {32'h0, pool(F[8],  F[9],  F[12], F[13])}, 64'h41600000);
      check("model 4x4 blk3", {32'h0, pool(F[10], F[11], F[14], F[15])}, 64'h41800000);
      check("model neg blk3", {32'h0, pool(F[10]^32'h80000000, F[11]^32'h80000000,
                                           F[14]^32'h80000000, F[15]^32'h80000000)}, 64'hC1300000);

      blk[0] = '{32'hBF800000, 32'hC0000000, 32'hBF000000, 32'hC0400000};
      blk[1] = '{32'h80000000, 32'h80000000, 32'h00000000, 32'h80000000};
      blk[2] = '{32'hFF800000, 32'hFF800000, 32'hFF800000, 32'hC2C80000};
      check("model negatives", {32'h0, pool(blk[0][0], blk[0][1], blk[0][2], blk[0][3])}, 64'hBF000000);
      check("model signed zero", {32'h0, pool(blk[1][0], blk[1][1], blk[1][2], blk[1][3])}, 64'h00000000);
      check("model -inf", {32'h0, pool(blk[2][0], blk[2][1], blk[2][2], blk[2][3])}, 64'hC2C80000);

      // 4x4 two-lane: continuous, then with random gaps, back to back.
      base = out_cnt[0];
      frame4(0);
      idle(0, 3);
      check("u4 outputs continuous frame", 64'(out_cnt[0] - base), 64'd4);
      base = out_cnt[0];
      frame4(5);
      idle(0, 3);
      check("u4 outputs gapped frame", 64'(out_cnt[0] - base), 64'd4);

      // Reset after 5 pixels, then a full frame.
      base = out_cnt[0];
      for (int i = 0; i < 5; i++) beat(0, {F[i] ^ 32'h80000000, F[i]}, 1'b1, 1'b0);
      beat(0, 64'($urandom), 1'b0, 1'b1);
      frame4(0);
      idle(0, 3);
      check("u4 outputs after mid-frame reset", 64'(out_cnt[0] - base), 64'd4);

      // Reset coinciding with the 4th pixel of the first block drops that result.
      base = out_cnt[0];
      for (int i = 0; i < 5; i++) beat(0, {F[i] ^ 32'h80000000, F[i]}, 1'b1, 1'b0);
      beat(0, {F[5] ^ 32'h80000000, F[5]}, 1'b1, 1'b1);
      frame4(2);
      idle(0, 3);
      check("u4 outputs after reset on block pixel", 64'(out_cnt[0] - base), 64'd4);

      // 2x2 corner cases, then random frames.
      for (int b = 0; b < 3; b++)
         for (int i = 0; i < 4; i++) beat(1, {32'h0, blk[b][i]}, 1'b1, 1'b0);
      for (int f = 0; f < 20; f++)
         for (int i = 0; i < 4; i++) begin
            beat(1, {32'h0, rnd_px()}, 1'b1, 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1, $urandom_range(1, 3));
         end
      idle(1, 3);
      check("u2 output count", 64'(out_cnt[1]), 64'd23);
      check("u2 last count",   64'(last_cnt[1]), 64'd23);

      // Default size: two back-to-back random frames.
      for (int i = 0; i < 2*104*104; i++) beat(2, {32'h0, rnd_px()}, 1'b1, 1'b0);
      idle(2, 4);

      for (int i = 0; i < 3; i++)
         check($sformatf("u%0d results never produced", i), 64'(exp_q[i].size()), 64'd0);
      check("u104 output count", 64'(out_cnt[2]), 64'd5408);
      check("u104 last count",   64'(last_cnt[2]), 64'd2);
      check("u4 last count",     64'(last_cnt[0]), 64'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
